// File: rtl/pll_seq_pkg.sv
// Shared definitions for the pixel-clock PLL reset sequencer.
// Contents:
//   pll_state_e      - sequencer state encoding
//   DEF_*            - timing constants for the 12 MHz reference clock
//   SIM_*            - shortened timing set used by the simulation bench
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    // 12 MHz reference: 2 us reset pulse, 1 ms lock timeout, 100 us settle.
    localparam int DEF_RST_CYCLES    = 24;
    localparam int DEF_LOCK_TIMEOUT  = 12000;
    localparam int DEF_SETTLE_CYCLES = 1200;
    localparam int DEF_LOCK_FILT     = 4;
    localparam int DEF_MAX_RETRY     = 3;
    localparam int DEF_CNT_W         = 16;

    // Short timings so a bench can walk every path in a few hundred cycles.
    localparam int SIM_RST_CYCLES    = 4;
    localparam int SIM_LOCK_TIMEOUT  = 50;
    localparam int SIM_SETTLE_CYCLES = 10;
    localparam int SIM_LOCK_FILT     = 3;
    localparam int SIM_MAX_RETRY     = 2;

endpackage

// File: rtl/pll_lock_filter.sv
// Lock-path conditioning for the PLL LOCK pin.
// A 2-FF synchronizer brings the asynchronous pin into the reference domain,
// then a consecutive-sample filter declares lock only after LOCK_FILT
// synchronized highs in a row.
// Ports:
//   clk        - reference clock
//   rst_n      - asynchronous active-low reset, clears synchronizer and filter
//   lock_async - raw PLL LOCK pin
//   lock_f     - filtered lock; set after LOCK_FILT highs, cleared by any low
//   lock_loss  - high while the synchronized lock has been low for 2 cycles
module pll_lock_filter #(
    parameter int LOCK_FILT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_async,
    output logic lock_f,
    output logic lock_loss
);

    localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;

    logic          sync1_r;
    logic          sync2_r;
    logic          low_seen_r;
    logic          lock_f_r;
    logic [FW-1:0] filt_cnt_r;

    // Synchronizer, previous-low memory and consecutive-high filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            low_seen_r <= 1'b0;
            lock_f_r   <= 1'b0;
            filt_cnt_r <= '0;
        end else begin
            sync1_r    <= lock_async;
            sync2_r    <= sync1_r;
            low_seen_r <= ~sync2_r;
            if (!sync2_r) begin
                filt_cnt_r <= '0;
                lock_f_r   <= 1'b0;
            end else if (filt_cnt_r == FW'(LOCK_FILT - 1)) begin
                // Counter parks here so lock_f stays set while samples stay high.
                lock_f_r   <= 1'b1;
            end else begin
                filt_cnt_r <= filt_cnt_r + 1'b1;
                lock_f_r   <= 1'b0;
            end
        end
    end

    assign lock_f    = lock_f_r;
    // Current and previous synchronized samples both low: a real loss, not a glitch.
    assign lock_loss = ~sync2_r & low_seen_r;

endmodule

// File: rtl/pll_reset_seq.sv
// Reset sequencer for the iCE40 pixel-clock PLL, clocked by the 12 MHz reference.
// Pulses PLL RESETB, waits for filtered lock, lets it settle, then releases the
// pixel-domain reset. Supervises lock while running, retries a bounded number
// of times and parks in FAIL (PLL held in reset) until a relock request.
// Ports:
//   REFERENCECLK - 12 MHz reference clock
//   RESET        - asynchronous active-low block reset
//   PLL_LOCK     - PLL LOCK pin (asynchronous)
//   RELOCK_REQ   - single-cycle request to restart the whole sequence
//   PLL_RESETB   - PLL reset, active low
//   SYS_RESETN   - downstream reset, active low, high only in RUN
//   PLL_OK       - high only in RUN
//   PLL_FAIL     - high only in FAIL
//   RETRY_CNT    - failed attempts in the current sequence, saturating at 3
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int LOCK_FILT     = DEF_LOCK_FILT,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       RELOCK_REQ,
    output logic       PLL_RESETB,
    output logic       SYS_RESETN,
    output logic       PLL_OK,
    output logic       PLL_FAIL,
    output logic [1:0] RETRY_CNT
);

    pll_state_e       state_r;
    pll_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [1:0]       retry_r;
    logic [1:0]       retry_s;
    logic             fail_attempt_s;
    logic             lock_f_s;
    logic             lock_loss_s;
    logic             resetb_r;
    logic             sys_resetn_r;
    logic             ok_r;
    logic             fail_r;

    pll_lock_filter #(
        .LOCK_FILT (LOCK_FILT)
    ) u_filt (
        .clk        (REFERENCECLK),
        .rst_n      (RESET),
        .lock_async (PLL_LOCK),
        .lock_f     (lock_f_s),
        .lock_loss  (lock_loss_s)
    );

    // Next-state, counter and retry decisions; a relock request overrides everything.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        retry_s        = retry_r;
        fail_attempt_s = 1'b0;
        if (RELOCK_REQ) begin
            state_s = PLL_RST;
            cnt_s   = '0;
            retry_s = 2'd0;
        end else begin
            case (state_r)
                PLL_RST: begin
                    if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
                        state_s = WAIT_LOCK;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_f_s) begin
                        state_s = SETTLE;
                        cnt_s   = '0;
                    end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        fail_attempt_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 1'b1;
                    end
                end
                SETTLE: begin
                    // A lock drop beats a simultaneous settle completion.
                    if (!lock_f_s) begin
                        fail_attempt_s = 1'b1;
                    end else if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_s = RUN;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + 1'b1;
                    end
                end
                RUN: begin
                    // lock_f is not used here: single-cycle lows are tolerated.
                    if (lock_loss_s) begin
                        state_s = PLL_RST;
                        cnt_s   = '0;
                        retry_s = 2'd0;
                    end else begin
                        state_s = RUN;
                    end
                end
                FAIL: begin
                    state_s = FAIL;
                end
                default: begin
                    state_s = PLL_RST;
                    cnt_s   = '0;
                    retry_s = 2'd0;
                end
            endcase
            if (fail_attempt_s) begin
                cnt_s = '0;
                if ((retry_r != 2'd3) && (int'(retry_r) < MAX_RETRY)) begin
                    retry_s = retry_r + 2'd1;
                    state_s = PLL_RST;
                end else begin
                    state_s = FAIL;
                end
            end else begin
                cnt_s = cnt_s;
            end
        end
    end

    // State, counter and outputs; outputs are decoded from the next state so
    // they change on the same edge as the state.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state_r      <= PLL_RST;
            cnt_r        <= '0;
            retry_r      <= 2'd0;
            resetb_r     <= 1'b0;
            sys_resetn_r <= 1'b0;
            ok_r         <= 1'b0;
            fail_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            retry_r      <= retry_s;
            resetb_r     <= (state_s == WAIT_LOCK) || (state_s == SETTLE) || (state_s == RUN);
            sys_resetn_r <= (state_s == RUN);
            ok_r         <= (state_s == RUN);
            fail_r       <= (state_s == FAIL);
        end
    end

    assign PLL_RESETB = resetb_r;
    assign SYS_RESETN = sys_resetn_r;
    assign PLL_OK     = ok_r;
    assign PLL_FAIL   = fail_r;
    assign RETRY_CNT  = retry_r;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq using the short simulation timing set.
// Output vector layout: {PLL_RESETB, SYS_RESETN, PLL_OK, PLL_FAIL, RETRY_CNT[1:0]}.
// cyc counts rising edges since RESET release; outputs are sampled 1 time unit
// after each edge.
module tb_pll_reset_seq
    import pll_seq_pkg::*;
;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_resetb;
    logic       sys_resetn;
    logic       pll_ok;
    logic       pll_fail;
    logic [1:0] retry_cnt;
    logic [5:0] outs;

    int checks;
    int errors;
    int cyc;

    pll_reset_seq #(
        .RST_CYCLES    (SIM_RST_CYCLES),
        .LOCK_TIMEOUT  (SIM_LOCK_TIMEOUT),
        .SETTLE_CYCLES (SIM_SETTLE_CYCLES),
        .LOCK_FILT     (SIM_LOCK_FILT),
        .MAX_RETRY     (SIM_MAX_RETRY),
        .CNT_W         (16)
    ) dut (
        .REFERENCECLK (clk),
        .RESET        (rst_n),
        .PLL_LOCK     (pll_lock),
        .RELOCK_REQ   (relock_req),
        .PLL_RESETB   (pll_resetb),
        .SYS_RESETN   (sys_resetn),
        .PLL_OK       (pll_ok),
        .PLL_FAIL     (pll_fail),
        .RETRY_CNT    (retry_cnt)
    );

    assign outs = {pll_resetb, sys_resetn, pll_ok, pll_fail, retry_cnt};

    initial clk = 1'b0;
    // 10-unit reference clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pll_lock   = 1'b1;
        relock_req = 1'b0;
        tick();
        tick();
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", outs, 6'b000000);
        end
    endtask

    task automatic test_normal_start();
        do_reset();
        run_to(3);
        checks++;
        if (outs !== 6'b000000) begin errors++; $display("FAIL start_c3: got %b expected %b", outs, 6'b000000); end
        run_to(4);
        checks++;
        if (outs !== 6'b100000) begin errors++; $display("FAIL start_c4: got %b expected %b", outs, 6'b100000); end
        run_to(10);
        pll_lock = 1'b1;
        run_to(14);
        checks++;
        if (dut.u_filt.lock_f !== 1'b0) begin errors++; $display("FAIL lockf_c14: got %b expected %b", dut.u_filt.lock_f, 1'b0); end
        run_to(15);
        checks++;
        if (dut.u_filt.lock_f !== 1'b1) begin errors++; $display("FAIL lockf_c15: got %b expected %b", dut.u_filt.lock_f, 1'b1); end
        run_to(25);
        checks++;
        if (outs !== 6'b100000) begin errors++; $display("FAIL start_c25: got %b expected %b", outs, 6'b100000); end
        run_to(26);
        checks++;
        if (outs !== 6'b111000) begin errors++; $display("FAIL start_c26: got %b expected %b", outs, 6'b111000); end
    endtask

    // Continues from RUN entered at cycle 26 with the lock pin high.
    task automatic test_run_loss();
        run_to(30);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        run_to(40);
        checks++;
        if (outs !== 6'b111000) begin errors++; $display("FAIL glitch_ignored: got %b expected %b", outs, 6'b111000); end
        pll_lock = 1'b0;
        run_to(43);
        pll_lock = 1'b1;
        checks++;
        if (outs !== 6'b111000) begin errors++; $display("FAIL loss_c43: got %b expected %b", outs, 6'b111000); end
        run_to(44);
        checks++;
        if (outs !== 6'b000000) begin errors++; $display("FAIL loss_c44: got %b expected %b", outs, 6'b000000); end
        run_to(47);
        checks++;
        if (outs !== 6'b000000) begin errors++; $display("FAIL loss_c47: got %b expected %b", outs, 6'b000000); end
        run_to(48);
        checks++;
        if (outs !== 6'b100000) begin errors++; $display("FAIL loss_c48: got %b expected %b", outs, 6'b100000); end
        run_to(58);
        checks++;
        if (outs !== 6'b100000) begin errors++; $display("FAIL loss_c58: got %b expected %b", outs, 6'b100000); end
        run_to(59);
        checks++;
        if (outs !== 6'b111000) begin errors++; $display("FAIL loss_c59: got %b expected %b", outs, 6'b111000); end
    endtask

    task automatic test_settle_glitch();
        do_reset();
        run_to(10);
        pll_lock = 1'b1;
        run_to(21);
        pll_lock = 1'b0;
        run_to(23);
        pll_lock = 1'b1;
        run_to(24);
        checks++;
        if (outs !== 6'b100000) begin errors++; $display("FAIL settle_c24: got %b expected %b", outs, 6'b100000); end
        run_to(25);
        checks++;
        if (outs !== 6'b000001) begin errors++; $display("FAIL settle_c25: got %b expected %b", outs, 6'b000001); end
        run_to(26);
        checks++;
        if (outs !== 6'b000001) begin errors++; $display("FAIL settle_c26: got %b expected %b", outs, 6'b000001); end
        run_to(39);
        checks++;
        if (outs !== 6'b100001) begin errors++; $display("FAIL settle_c39: got %b expected %b", outs, 6'b100001); end
        run_to(40);
        checks++;
        if (outs !== 6'b111001) begin errors++; $display("FAIL settle_c40: got %b expected %b", outs, 6'b111001); end
    endtask

    task automatic test_timeouts_fail();
        do_reset();
        run_to(4);
        checks++;
        if (outs !== 6'b100000) begin errors++; $display("FAIL to_c4: got %b expected %b", outs, 6'b100000); end
        run_to(53);
        checks++;
        if (outs !== 6'b100000) begin errors++; $display("FAIL to_c53: got %b expected %b", outs, 6'b100000); end
        run_to(54);
        checks++;
        if (outs !== 6'b000001) begin errors++; $display("FAIL to_c54: got %b expected %b", outs, 6'b000001); end
        run_to(58);
        checks++;
        if (outs !== 6'b100001) begin errors++; $display("FAIL to_c58: got %b expected %b", outs, 6'b100001); end
        run_to(107);
        checks++;
        if (outs !== 6'b100001) begin errors++; $display("FAIL to_c107: got %b expected %b", outs, 6'b100001); end
        run_to(108);
        checks++;
        if (outs !== 6'b000010) begin errors++; $display("FAIL to_c108: got %b expected %b", outs, 6'b000010); end
        run_to(112);
        checks++;
        if (outs !== 6'b100010) begin errors++; $display("FAIL to_c112: got %b expected %b", outs, 6'b100010); end
        run_to(161);
        checks++;
        if (outs !== 6'b100010) begin errors++; $display("FAIL to_c161: got %b expected %b", outs, 6'b100010); end
        run_to(162);
        checks++;
        if (outs !== 6'b000110) begin errors++; $display("FAIL to_fail_c162: got %b expected %b", outs, 6'b000110); end
        run_to(300);
        checks++;
        if (outs !== 6'b000110) begin errors++; $display("FAIL fail_sticky: got %b expected %b", outs, 6'b000110); end
    endtask

    // Continues from FAIL at cycle 300 with the lock pin low.
    task automatic test_relock();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++;
        if (outs !== 6'b000000) begin errors++; $display("FAIL relock_from_fail: got %b expected %b", outs, 6'b000000); end
        run_to(305);
        checks++;
        if (outs !== 6'b100000) begin errors++; $display("FAIL relock_c305: got %b expected %b", outs, 6'b100000); end
        run_to(355);
        checks++;
        if (outs !== 6'b000001) begin errors++; $display("FAIL relock_c355: got %b expected %b", outs, 6'b000001); end
        run_to(408);
        checks++;
        if (outs !== 6'b100001) begin errors++; $display("FAIL relock_c408: got %b expected %b", outs, 6'b100001); end
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++;
        if (outs !== 6'b000000) begin errors++; $display("FAIL relock_vs_timeout: got %b expected %b", outs, 6'b000000); end
        run_to(412);
        checks++;
        if (outs !== 6'b000000) begin errors++; $display("FAIL relock_c412: got %b expected %b", outs, 6'b000000); end
        run_to(413);
        checks++;
        if (outs !== 6'b100000) begin errors++; $display("FAIL relock_c413: got %b expected %b", outs, 6'b100000); end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_to(10);
        pll_lock = 1'b1;
        run_to(20);
        checks++;
        if (outs !== 6'b100000) begin errors++; $display("FAIL ares_settle: got %b expected %b", outs, 6'b100000); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b000000) begin errors++; $display("FAIL ares_immediate: got %b expected %b", outs, 6'b000000); end
        tick();
        tick();
        checks++;
        if (outs !== 6'b000000) begin errors++; $display("FAIL ares_held: got %b expected %b", outs, 6'b000000); end
        rst_n = 1'b1;
    endtask

    // Scenario sequence and summary.
    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        test_reset();
        test_normal_start();
        test_run_loss();
        test_settle_glitch();
        test_timeouts_fail();
        test_relock();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Control-side companion to the iCE40 pixel-clock PLL (12 MHz in, 25.175 MHz out).
- Drives the PLL's active-low RESETB input and consumes its LOCK output.
- Sequences PLL reset, lock acquisition and settle time, then releases the system reset used by the VGA pixel domain.
- Supervises lock after start-up, retries a bounded number of times and flags a permanent failure.
- Runs entirely on the 12 MHz reference clock.

Parameters:
- RST_CYCLES, 24: cycles PLL_RESETB is held low per attempt (2 µs at 12 MHz).
- LOCK_TIMEOUT, 12000: cycles to wait for filtered lock per attempt (1 ms).
- SETTLE_CYCLES, 1200: cycles filtered lock must hold before SYS_RESETN is released (100 µs).
- LOCK_FILT, 4: consecutive synchronized-high samples needed to declare lock.
- MAX_RETRY, 3: failed attempts allowed after the first attempt before FAIL.
- CNT_W, 16: width of the shared cycle counter; must hold the largest of the three cycle parameters.

Ports:
- REFERENCECLK, in, 1: 12 MHz clock; same net as the PLL reference.
- RESET, in, 1: asynchronous, active-low block reset.
- PLL_LOCK, in, 1: PLL LOCK output; asynchronous, synchronized internally.
- RELOCK_REQ, in, 1: single-cycle request to restart the full sequence.
- PLL_RESETB, out, 1: to PLL RESETB; active low.
- SYS_RESETN, out, 1: active-low downstream reset; the pixel domain re-synchronizes it.
- PLL_OK, out, 1: high only in RUN.
- PLL_FAIL, out, 1: high only in FAIL.
- RETRY_CNT, out, 2: failed attempts in the current sequence; saturates at 3.

Behaviour:
- All outputs registered.
- RESET low (asynchronous): state=PLL_RST, counter=0, PLL_RESETB=0, SYS_RESETN=0, PLL_OK=0, PLL_FAIL=0, RETRY_CNT=0, synchronizer and filter cleared.
- Lock path:
  - 2-FF synchronizer, then filter. lock_f sets after LOCK_FILT consecutive synchronized highs and clears on any synchronized low.
  - Pin-to-lock_f latency: 2+LOCK_FILT cycles.
- PLL_RST: PLL_RESETB=0. Counter counts to RST_CYCLES-1, then counter=0, go WAIT_LOCK. PLL_RESETB rises on that same edge.
- WAIT_LOCK: PLL_RESETB=1.
  - lock_f=1: counter=0, go SETTLE.
  - Counter reaches LOCK_TIMEOUT-1 without lock: this is a failed attempt.
- SETTLE:
  - lock_f drops: failed attempt.
  - Counter reaches SETTLE_CYCLES-1 with lock_f held: go RUN. SYS_RESETN=1 and PLL_OK=1 from the next edge.
- Failed attempt:
  - RETRY_CNT<MAX_RETRY: RETRY_CNT+1, counter=0, go PLL_RST.
  - Otherwise: go FAIL.
- RUN:
  - Synchronized lock low for 2 consecutive cycles: loss of lock. Next edge SYS_RESETN=0, PLL_OK=0, RETRY_CNT=0, go PLL_RST.
  - A single-cycle low is ignored, but it still clears lock_f.
- FAIL: PLL_RESETB=0 (PLL held off), SYS_RESETN=0, PLL_FAIL=1. Sticky until RELOCK_REQ or RESET.
- RELOCK_REQ (any state):
  - Next edge: counter=0, RETRY_CNT=0, PLL_FAIL=0, PLL_OK=0, SYS_RESETN=0, go PLL_RST.
  - Takes priority over every simultaneous event: timeout, lock loss, settle completion.
- Counter never wraps; it is cleared on every state change.
- RESET asserted mid-sequence: immediate return to reset values, no partial completion.
- SYS_RESETN is never high unless state=RUN.

Decomposition:
- Package pll_seq_pkg:
  - State encoding: PLL_RST, WAIT_LOCK, SETTLE, RUN, FAIL.
  - Default timing constants for 12 MHz.
  - Simulation-scale constant set for the bench.
- Sub-module pll_lock_filter: 2-FF synchronizer plus LOCK_FILT consecutive-sample filter. Outputs lock_f and the 2-consecutive-low loss strobe.

Test Plan (sim params RST_CYCLES=4, LOCK_TIMEOUT=50, SETTLE_CYCLES=10, LOCK_FILT=3, MAX_RETRY=2):
- Normal start: RESET released at cycle 0, PLL_LOCK high from cycle 10 -> PLL_RESETB high at cycle 4; lock_f at cycle 15; SYS_RESETN and PLL_OK high at cycle 26; RETRY_CNT=0.
- Timeouts to fail: PLL_LOCK held low -> three 4-cycle PLL_RESETB low pulses; RETRY_CNT steps 0→1→2; PLL_FAIL high after the third timeout; PLL_RESETB then stays low; SYS_RESETN never rises.
- Lock loss in RUN: drop PLL_LOCK for 1 cycle -> no change. Drop it for 3 cycles -> SYS_RESETN=0 and PLL_OK=0 4 cycles after the drop (2 sync + 2 detect); PLL_RESETB low for 4 cycles; full re-sequence.
- Lock glitch in SETTLE: PLL_LOCK low for 2 cycles at settle count 5 -> RETRY_CNT=1, back to PLL_RST, SYS_RESETN stays 0.
- RELOCK_REQ from FAIL, same cycle as a timeout in WAIT_LOCK -> PLL_FAIL=0, RETRY_CNT=0, PLL_RST entered next edge; RELOCK_REQ wins.
- Asynchronous RESET asserted mid-SETTLE between clock edges -> all outputs at reset values immediately, before the next edge.
